// File: rtl/multi_port_fifo_pkg.sv
// Shared helpers for the multi-port FIFO. The block stays parameter-generic,
// so this package only carries width arithmetic used by every file.
package multi_port_fifo_pkg;

    // Width of a field that must hold any value 0..ports inclusive.
    function automatic int num_width(input int ports);
        return (ports < 1) ? 1 : $clog2(ports + 1);
    endfunction

endpackage

// File: rtl/multi_port_fifo_if.sv
// Bundle of push/pop/status signals between the producer/consumer stages
// and the multi-port FIFO.
//
// Handshake: a request is the pair (num, accept). num > 0 means the requester
// wants to move num entries this cycle. accept is combinational from num and
// the FIFO's registered state, and is all-or-nothing: the transfer of all num
// entries happens at the rising edge when accept is high, otherwise nothing
// moves and the requester must hold num/data and retry. num must never depend
// on accept. num == 0 is always accepted and moves nothing.
interface multi_port_fifo_if #(
    parameter int kWidth     = 32,
    parameter int kAddrWidth = 4,
    parameter int kPorts     = 2
);
    import multi_port_fifo_pkg::*;

    localparam int kNumW = num_width(kPorts);

    logic                     flush;
    logic [kNumW-1:0]         write_num;
    logic [kPorts*kWidth-1:0] write_data;
    logic                     write_accept;
    logic [kNumW-1:0]         read_num;
    logic [kPorts*kWidth-1:0] read_data;
    logic [kPorts-1:0]        read_valid;
    logic                     read_accept;
    logic [kAddrWidth:0]      count;
    logic                     is_full;
    logic                     is_empty;
    logic                     almost_full;

    modport slave (
        input  flush, write_num, write_data, read_num,
        output write_accept, read_data, read_valid, read_accept,
               count, is_full, is_empty, almost_full
    );

    modport master (
        output flush, write_num, write_data, read_num,
        input  write_accept, read_data, read_valid, read_accept,
               count, is_full, is_empty, almost_full
    );

endinterface

// File: rtl/multi_port_fifo_ring_mem.sv
// Ring storage for the multi-port FIFO: kPorts write ports at consecutive
// addresses from a base, and kPorts combinational read ports at consecutive
// addresses from another base. Addresses wrap modulo the depth.
module multi_port_fifo_ring_mem #(
    parameter int kWidth     = 32,
    parameter int kAddrWidth = 4,
    parameter int kPorts     = 2
) (
    input  logic                     clk,
    input  logic [kPorts-1:0]        write_en,
    input  logic [kAddrWidth-1:0]    write_base,
    input  logic [kPorts*kWidth-1:0] write_data,
    input  logic [kAddrWidth-1:0]    read_base,
    output logic [kPorts*kWidth-1:0] read_data
);
    localparam int kSize = 2 ** kAddrWidth;

    // Contents are deliberately not reset; the pointers decide what is live.
    logic [kWidth-1:0] mem [kSize];

    // Commit each enabled slot; kPorts <= kSize keeps the addresses distinct.
    always_ff @(posedge clk) begin
        for (int i = 0; i < kPorts; i++) begin
            if (write_en[i]) begin
                mem[write_base + kAddrWidth'(i)] <= write_data[i*kWidth +: kWidth];
            end
        end
    end

    // Present the entries at read_base, read_base+1, ... combinationally.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < kPorts; i++) begin
            read_data[i*kWidth +: kWidth] = mem[read_base + kAddrWidth'(i)];
        end
    end

endmodule

// File: rtl/multi_port_fifo.sv
// First-word-fall-through FIFO that pushes and pops up to kPorts entries per
// cycle. Holds the pointers, acceptance logic, status flags and the masking
// of unused head slots; storage lives in the ring memory sub-module.
module multi_port_fifo
    import multi_port_fifo_pkg::*;
#(
    parameter int kWidth            = 32,
    parameter int kAddrWidth        = 4,
    parameter int kPorts            = 2,
    parameter int kAlmostFullThresh = 2 ** kAddrWidth - 2
) (
    input  logic             clk,
    input  logic             rst,
    multi_port_fifo_if.slave bus
);
    localparam int kNumW = num_width(kPorts);
    localparam int kPtrW = kAddrWidth + 1;
    localparam logic [kPtrW-1:0] kSizeV   = kPtrW'(2 ** kAddrWidth);
    localparam logic [kPtrW-1:0] kThreshV = kPtrW'(kAlmostFullThresh);

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [kPtrW-1:0]         write_ptr;
    logic [kPtrW-1:0]         read_ptr;
    logic [kPtrW-1:0]         count;
    logic [kPtrW-1:0]         free;
    logic [kPtrW-1:0]         write_num_ext;
    logic [kPtrW-1:0]         read_num_ext;
    logic                     write_accept;
    logic                     read_accept;
    logic [kPorts-1:0]        write_en;
    logic [kPorts*kWidth-1:0] mem_data;

    // Acceptance looks only at pre-edge occupancy: a same-cycle pop never
    // makes room for a push.
    always_comb begin
        count         = write_ptr - read_ptr;
        free          = kSizeV - count;
        write_num_ext = kPtrW'(bus.write_num);
        read_num_ext  = kPtrW'(bus.read_num);
        write_accept  = (write_num_ext <= free);
        read_accept   = (read_num_ext <= count);
    end

    // Enable the first write_num slots of an accepted, non-flushed push.
    always_comb begin
        write_en = '0;
        for (int i = 0; i < kPorts; i++) begin
            write_en[i] = write_accept && !bus.flush && (kNumW'(i) < bus.write_num);
        end
    end

    // Pointer update; flush wins over both push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else if (bus.flush) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else begin
            if (write_accept) write_ptr <= write_ptr + write_num_ext;
            if (read_accept)  read_ptr  <= read_ptr + read_num_ext;
        end
    end

    multi_port_fifo_ring_mem #(
        .kWidth     (kWidth),
        .kAddrWidth (kAddrWidth),
        .kPorts     (kPorts)
    ) u_mem (
        .clk        (clk),
        .write_en   (write_en),
        .write_base (write_ptr[kAddrWidth-1:0]),
        .write_data (bus.write_data),
        .read_base  (read_ptr[kAddrWidth-1:0]),
        .read_data  (mem_data)
    );

    // Head slots beyond the occupancy read as zero and are flagged invalid.
    always_comb begin
        bus.read_valid = '0;
        bus.read_data  = '0;
        for (int i = 0; i < kPorts; i++) begin
            bus.read_valid[i] = (kPtrW'(i) < count);
            if (bus.read_valid[i]) begin
                bus.read_data[i*kWidth +: kWidth] = mem_data[i*kWidth +: kWidth];
            end
        end
    end

    assign bus.write_accept = write_accept;
    assign bus.read_accept  = read_accept;
    assign bus.count        = count;
    assign bus.is_full      = (count == kSizeV);
    assign bus.is_empty     = (count == '0);
    assign bus.almost_full  = (count >= kThreshV);

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed plus short random bench for multi_port_fifo in a 4-deep, 2-port,
// 8-bit configuration. A queue model tracks the live entries.
module tb_multi_port_fifo;

    localparam int kWidth     = 8;
    localparam int kAddrWidth = 2;
    localparam int kPorts     = 2;
    localparam int kThresh    = 3;
    localparam int kSize      = 4;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    logic [kWidth-1:0] exp_q[$];
    logic [kWidth-1:0] out_log[$];

    multi_port_fifo_if #(
        .kWidth     (kWidth),
        .kAddrWidth (kAddrWidth),
        .kPorts     (kPorts)
    ) bus ();

    multi_port_fifo #(
        .kWidth            (kWidth),
        .kAddrWidth        (kAddrWidth),
        .kPorts            (kPorts),
        .kAlmostFullThresh (kThresh)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every status output and head slot against the queue model.
    task automatic check_state(input string tag);
        int size;
        size = exp_q.size();
        check({tag, ".count"}, 32'(bus.count), 32'(size));
        check({tag, ".is_empty"}, 32'(bus.is_empty), 32'(size == 0));
        check({tag, ".is_full"}, 32'(bus.is_full), 32'(size == kSize));
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'(size >= kThresh));
        for (int i = 0; i < kPorts; i++) begin
            check($sformatf("%s.read_valid[%0d]", tag, i), 32'(bus.read_valid[i]), 32'(i < size));
            check($sformatf("%s.read_data[%0d]", tag, i), 32'(bus.read_data[i*kWidth +: kWidth]),
                  (i < size) ? 32'(exp_q[i]) : 32'h0);
        end
    endtask

    // One clocked step: drive a request, check acceptance, update the model.
    task automatic drive(input string tag, input int wn, input logic [7:0] d0, input logic [7:0] d1,
                         input int rn, input logic fl);
        int  size;
        logic exp_wacc;
        logic exp_racc;
        bus.write_num  = 2'(wn);
        bus.write_data = {d1, d0};
        bus.read_num   = 2'(rn);
        bus.flush      = fl;
        #1;
        size     = exp_q.size();
        exp_wacc = (wn <= kSize - size);
        exp_racc = (rn <= size);
        check({tag, ".write_accept"}, 32'(bus.write_accept), 32'(exp_wacc));
        check({tag, ".read_accept"}, 32'(bus.read_accept), 32'(exp_racc));
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_racc) begin
                for (int j = 0; j < rn; j++) out_log.push_back(exp_q.pop_front());
            end
            if (exp_wacc) begin
                if (wn >= 1) exp_q.push_back(d0);
                if (wn >= 2) exp_q.push_back(d1);
            end
        end
        #1;
        bus.write_num  = '0;
        bus.write_data = '0;
        bus.read_num   = '0;
        bus.flush      = 1'b0;
        check_state({tag, ".post"});
    endtask

    initial begin
        rst            = 1'b0;
        bus.flush      = 1'b0;
        bus.write_num  = '0;
        bus.write_data = '0;
        bus.read_num   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check("reset.write_accept", 32'(bus.write_accept), 32'd1);
        check("reset.read_accept", 32'(bus.read_accept), 32'd1);
        rst = 1'b1;

        // Reset in the middle of operation takes effect without an edge
        drive("rm_push2", 2, 8'hA1, 8'hA2, 0, 1'b0);
        drive("rm_push1", 1, 8'hA3, 8'h00, 0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_state("rm_async");
        #1;
        rst = 1'b1;
        drive("rm_after", 2, 8'hB1, 8'hB2, 0, 1'b0);
        drive("rm_drain", 0, 8'h00, 8'h00, 2, 1'b0);

        // Dual push then dual pop
        drive("dual_push", 2, 8'h11, 8'h22, 0, 1'b0);
        check("dual.slot0", 32'(bus.read_data[7:0]), 32'h11);
        check("dual.slot1", 32'(bus.read_data[15:8]), 32'h22);
        drive("dual_pop", 0, 8'h00, 8'h00, 2, 1'b0);

        // Full: a same-cycle pop does not make room for a push
        drive("full_a", 2, 8'h31, 8'h32, 0, 1'b0);
        drive("full_b", 2, 8'h33, 8'h34, 0, 1'b0);
        check("full.is_full", 32'(bus.is_full), 32'd1);
        drive("full_rw", 1, 8'h35, 8'h00, 1, 1'b0);
        check("full_rw.count", 32'(bus.count), 32'd3);
        drive("full_d1", 0, 8'h00, 8'h00, 2, 1'b0);
        drive("full_d2", 0, 8'h00, 8'h00, 1, 1'b0);

        // Wrap-around streaming of 0x01..0x0C
        out_log.delete();
        for (int k = 0; k < 6; k++) begin
            drive("wrap", 2, 8'(2*k + 1), 8'(2*k + 2), (k == 0) ? 0 : 2, 1'b0);
            check("wrap.count_le2", 32'(bus.count <= 2), 32'd1);
        end
        drive("wrap_end", 0, 8'h00, 8'h00, 2, 1'b0);
        check("wrap.out_len", 32'(out_log.size()), 32'd12);
        for (int k = 0; k < 12 && k < out_log.size(); k++) begin
            check($sformatf("wrap.order[%0d]", k), 32'(out_log[k]), 32'(k + 1));
        end

        // Underflow: pop 2 with only 1 present is rejected
        drive("uf_push", 1, 8'h55, 8'h00, 0, 1'b0);
        drive("uf_pop2", 0, 8'h00, 8'h00, 2, 1'b0);
        check("uf.slot0", 32'(bus.read_data[7:0]), 32'h55);
        check("uf.valid", 32'(bus.read_valid), 32'b01);
        drive("uf_pop1", 0, 8'h00, 8'h00, 1, 1'b0);

        // Flush with a concurrent push; the pushed value must never appear
        drive("fl_a", 2, 8'h61, 8'h62, 0, 1'b0);
        drive("fl_b", 1, 8'h63, 8'h00, 0, 1'b0);
        drive("fl_flush", 1, 8'h66, 8'h00, 0, 1'b1);
        check("fl.read_data", 32'(bus.read_data), 32'h0);
        drive("fl_next", 1, 8'h77, 8'h00, 0, 1'b0);
        check("fl.slot0", 32'(bus.read_data[7:0]), 32'h77);

        // Random mix of pushes, pops and rare flushes
        for (int k = 0; k < 40; k++) begin
            drive("rand", $urandom_range(0, 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2), 1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_port_fifo.md
Name: multi_port_fifo

Overview:
- Parametrised successor to the core's single-entry FIFO for superscalar front-end/issue paths.
- Accepts up to kPorts entries per cycle and retires up to kPorts entries per cycle, simultaneously.
- First-word-fall-through: head entries are presented combinationally, and the block provides occupancy count, almost-full and synchronous flush.
- Sits between fetch/decode stages and rename/dispatch.

Parameters:
- kWidth, 32, bits per entry
- kAddrWidth, 4, log2 of depth; depth kSize = 2**kAddrWidth
- kPorts, 2, max entries written and read per cycle; legal range 1..kSize
- kAlmostFullThresh, 2**kAddrWidth - 2, almost_full asserts when count >= this value

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- write_num  in  kNumW  number of entries to push this cycle (0..kPorts); kNumW = $clog2(kPorts+1)
- write_data  in  kPorts*kWidth  slot i in bits [i*kWidth +: kWidth]; slot 0 is pushed first
- write_accept  out  1  request accepted (write_num <= free)
- read_num  in  kNumW  number of entries to pop this cycle (0..kPorts)
- read_data  out  kPorts*kWidth  head entries; slot 0 is the oldest
- read_valid  out  kPorts  bit i = slot i holds a real entry (i < count)
- read_accept  out  1  pop accepted (read_num <= count)
- count  out  kAddrWidth+1  current occupancy, 0..kSize
- is_full  out  1  count == kSize
- is_empty  out  1  count == 0
- almost_full  out  1  count >= kAlmostFullThresh

Behaviour:
- Reset (rst low, async):
  - write_ptr, read_ptr and count clear to 0 immediately.
  - Outputs: is_empty=1, is_full=0, almost_full=0 (unless kAlmostFullThresh==0), read_valid=0, read_data=0, read_accept=(read_num==0), write_accept=(write_num<=kSize).
  - Memory contents are not cleared.
- Pointers are kAddrWidth+1 bits and wrap naturally mod 2*kSize; memory is indexed by the low kAddrWidth bits. count = write_ptr - read_ptr, in kAddrWidth+1 bits.
- free = kSize - count, computed from registered state only.
- Write is all-or-nothing:
  - write_accept = (write_num <= free).
  - On accept, slots 0..write_num-1 are written to mem[(write_ptr+i) mod kSize] at the clock edge, and write_ptr += write_num.
  - On reject, nothing is written and the pointer is unchanged; the requester must hold and retry.
- Read is all-or-nothing:
  - read_accept = (read_num <= count).
  - On accept, read_ptr += read_num at the clock edge; on reject, no change.
- Same-cycle reads do not create write space:
  - Acceptance uses pre-edge count only.
  - When full, a write of 1 alongside a read of 1 rejects the write and accepts the read.
- Simultaneous accepted read and write are independent; next count = count + write_num - read_num.
- FWFT read path:
  - read_data slot i = mem[(read_ptr+i) mod kSize] when i < count, else 0 (combinational from registered state).
  - An entry written at edge N is visible on read_data after edge N; there is no same-cycle bypass.
- write_accept and read_accept are combinational from write_num/read_num and registered state. Upstream must not make write_num depend on write_accept.
- flush has priority over read and write:
  - Both pointers are set to 0 at the next edge; no write is committed that cycle.
  - write_accept and read_accept still report their normal combinational values during flush, but are ignored.
- is_full, is_empty, almost_full and count are all registered-state functions; no glitch paths from inputs.
- Boundary cases:
  - count==kSize: read_valid is all ones for slots < min(kPorts,kSize).
  - write_num > kPorts is out of contract; the bench must never drive it.

Decomposition:
- Shared package (core utility pkg):
  - clog2-based width helper function for kNumW.
  - No typedefs; the block stays parameter-generic.
- Sub-module fifo_ring_mem:
  - kSize x kWidth register array with kPorts write ports at consecutive addresses from a base pointer.
  - kPorts combinational read ports at consecutive addresses from a base pointer.
- Top level holds pointers, accept logic, flags and output masking.

Test Plan (kWidth=8, kAddrWidth=2, kPorts=2, kAlmostFullThresh=3):
- Reset mid-operation: fill 3 entries, assert rst low between edges → count=0, is_empty=1, read_valid=00 immediately; after release, push 2 → count=2.
- Dual push then dual pop: push {0x11,0x22} → read_data slot0=0x11, slot1=0x22, read_valid=11; pop 2 → is_empty=1, read_data=0.
- Full rejection: push 2, push 2 → count=4, is_full=1, almost_full=1; push 1 with pop 1 → write_accept=0, read_accept=1, count=3, almost_full=1.
- Wrap-around: 6 cycles of push 2 / pop 2 with values 0x01..0x0C → output order exactly 0x01..0x0C, count never exceeds 2, pointer wrap invisible.
- Underflow: count=1, request pop 2 → read_accept=0, count stays 1, read_data slot0 unchanged, read_valid=01.
- Flush with concurrent push: count=3, flush=1 together with push 1 → next cycle count=0, is_empty=1, and the pushed value never appears on read_data.
